// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: zero-fills a 2**ADDR_W x DATA_W dual-port RAM after reset, forwards user writes, scans reads to a display register.
// Latency: wr_req -> ram_wren/wr_ack 1 cycle; scan address change -> disp_addr/disp_data 2 cycles; clear takes 2**ADDR_W cycles.
// Backpressure: none; requests arriving during the clear park in a one-deep slot where the last request wins.
// Option: define RAM_SCAN_BYPASS_EN to forward fresh writes of the displayed word straight into disp_data.
module ram_scan_ctrl #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 3,
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              scan_en,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_rdaddress,
  input  logic [DATA_W-1:0] ram_dataout,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid
);

  localparam int TICK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [ADDR_W-1:0]   scan_q, scan_d;
  logic [ADDR_W-1:0]   addr_d1_q, addr_d1_d;
  logic                d1_vld_q, d1_vld_d;
  logic [ADDR_W-1:0]   disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_vld_q, disp_vld_d;
  logic                wren_q, wren_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   disp_sel;

`ifdef RAM_SCAN_BYPASS_EN
  // The write issued last cycle lands in the RAM at the same edge the displayed word is read,
  // so the old-data read returned now is stale; remember that write to cover this cycle too.
  logic                lw_vld_q, lw_vld_d;
  logic [ADDR_W-1:0]   lw_addr_q, lw_addr_d;
  logic [DATA_W-1:0]   lw_data_q, lw_data_d;

  // Pick the freshest value for the word held in addr_d1: current write, previous write, then RAM.
  always_comb begin
    lw_vld_d  = wren_q;
    lw_addr_d = waddr_q;
    lw_data_d = wdata_q;
    disp_sel  = ram_dataout;
    if (wren_q && (waddr_q == addr_d1_q)) begin
      disp_sel = wdata_q;
    end else if (lw_vld_q && (lw_addr_q == addr_d1_q)) begin
      disp_sel = lw_data_q;
    end
  end

  // Last-write tracking registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lw_vld_q  <= 1'b0;
      lw_addr_q <= '0;
      lw_data_q <= '0;
    end else begin
      lw_vld_q  <= lw_vld_d;
      lw_addr_q <= lw_addr_d;
      lw_data_q <= lw_data_d;
    end
  end
`else
  assign disp_sel = ram_dataout;
`endif

  // Next-state logic: clear sequencing, write forwarding, scan tick and display pipeline.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    tick_d      = tick_q;
    scan_d      = scan_q;
    addr_d1_d   = addr_d1_q;
    d1_vld_d    = d1_vld_q;
    disp_addr_d = disp_addr_q;
    disp_data_d = disp_data_q;
    disp_vld_d  = disp_vld_q;
    wren_d      = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    ack_d       = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        wren_d    = 1'b1;
        waddr_d   = clr_cnt_q;
        wdata_d   = '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_RUN;
        end
        // Park user requests until the RAM is clean; a newer one replaces an older one.
        if (wr_req) begin
          pend_vld_d  = 1'b1;
          pend_addr_d = wr_addr;
          pend_data_d = wr_data;
        end
      end
      ST_RUN: begin
        // A live request goes straight out; it also supersedes anything still parked.
        if (wr_req) begin
          wren_d     = 1'b1;
          ack_d      = 1'b1;
          waddr_d    = wr_addr;
          wdata_d    = wr_data;
          pend_vld_d = 1'b0;
        end else if (pend_vld_q) begin
          wren_d     = 1'b1;
          ack_d      = 1'b1;
          waddr_d    = pend_addr_q;
          wdata_d    = pend_data_q;
          pend_vld_d = 1'b0;
        end
        if (scan_en) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            scan_d = scan_q + ADDR_W'(1);
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        // addr_d1 lines up with the RAM's one-cycle read latency; the display only loads once it is primed.
        addr_d1_d = scan_q;
        d1_vld_d  = 1'b1;
        if (d1_vld_q) begin
          disp_addr_d = addr_d1_q;
          disp_data_d = disp_sel;
          disp_vld_d  = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    busy_d = (state_d == ST_CLEAR);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      tick_q      <= '0;
      scan_q      <= '0;
      addr_d1_q   <= '0;
      d1_vld_q    <= 1'b0;
      disp_addr_q <= '0;
      disp_data_q <= '0;
      disp_vld_q  <= 1'b0;
      wren_q      <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      tick_q      <= tick_d;
      scan_q      <= scan_d;
      addr_d1_q   <= addr_d1_d;
      d1_vld_q    <= d1_vld_d;
      disp_addr_q <= disp_addr_d;
      disp_data_q <= disp_data_d;
      disp_vld_q  <= disp_vld_d;
      wren_q      <= wren_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign ram_wren      = wren_q;
  assign ram_wraddress = waddr_q;
  assign ram_datain    = wdata_q;
  assign wr_ack        = ack_q;
  assign busy          = busy_q;
  assign ram_rdaddress = scan_q;
  assign disp_addr     = disp_addr_q;
  assign disp_data     = disp_data_q;
  assign disp_valid    = disp_vld_q;

endmodule
